imem_loader: RTL
================

Name: imem_loader

Overview:
- Writes a program image into the instruction SRAM before the processor starts fetching from it.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Writes each word at consecutive word-aligned byte addresses, then reads it back to verify it.
- Drives the same cs/oe/we/addr/din/dout SRAM interface that instruction fetch uses, and holds the CPU off while loading.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- MAX_WORDS, 1024, largest allowed image size in words.
- BIG_ENDIAN, 1, 1 = first byte of each word goes to [31:24]; 0 = first byte goes to [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- num_words  in  16  image length in words; sampled on an accepted start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_cs  out  1  SRAM chip select.
- mem_oe  out  1  SRAM output enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  32  SRAM byte address.
- mem_din  out  32  SRAM write data.
- mem_dout  in  32  SRAM read data; combinational in the same cycle as addr/oe.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag.
- words_written  out  16  count of verified words.
- cpu_hold  out  1  keeps fetch/PC stalled; equals busy OR err.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, addr reg=BASE_ADDR, word reg=0, byte_idx=0, count=0.
  - All outputs 0, except mem_addr=BASE_ADDR.
  - Any partially assembled word is discarded. Words already in SRAM are untouched.
- States: IDLE, COLLECT, WRITE, VERIFY, DONE, ERROR.
- IDLE:
  - byte_ready=0, mem_cs/oe/we=0.
  - start with num_words==0 -> DONE.
  - start with num_words>MAX_WORDS -> ERROR.
  - Any other start -> COLLECT, with addr=BASE_ADDR, count=0, byte_idx=0, err cleared, num_words latched.
- COLLECT:
  - byte_ready=1.
  - On byte_valid&&byte_ready, byte_data goes into slot byte_idx (placement per BIG_ENDIAN) and byte_idx increments.
  - When the 4th byte is accepted -> WRITE; byte_idx wraps to 0.
  - byte_valid low: stay, no timeout.
- WRITE: single cycle with mem_cs=1, mem_we=1, mem_oe=0, mem_addr=addr, mem_din=word; byte_ready=0; -> VERIFY.
- VERIFY: single cycle with mem_cs=1, mem_oe=1, mem_we=0, same addr.
  - mem_dout!=word -> ERROR; addr and count are not advanced.
  - Match -> count+1, addr+4 (32-bit wrap); then DONE if count+1==latched num_words, else COLLECT.
- DONE: done=1 for exactly one cycle; busy=0; -> IDLE. words_written holds its value until the next accepted start.
- ERROR:
  - err=1, cpu_hold=1, all memory strobes 0.
  - Stays until a valid start, which is handled as in IDLE, or until reset.
  - A start with num_words==0 from ERROR -> DONE and clears err.
- busy=1 in COLLECT, WRITE and VERIFY.
- start while busy is ignored.
- mem_we and mem_oe are never high in the same cycle.
- Latency: 4th byte accepted in cycle N -> WRITE in N+1 -> VERIFY in N+2 -> next state in N+3. Minimum 6 cycles per word.
- words_written = count, registered.

Decomposition:
- Shared package imem_pkg:
  - State encoding (3-bit localparams).
  - WORD_BYTES=4, ADDR_STRIDE=32'd4.
  - SRAM strobe constants (RD: cs=1 oe=1 we=0; WR: cs=1 oe=0 we=1; OFF: all 0).
- One sub-module, word_packer: byte handshake, byte_idx counter, endian placement, word_ready pulse.
- The FSM, address and count registers, and compare logic stay in imem_loader.

Test Plan:
- Reset, then start with num_words=2 and bytes 12 34 56 78 9A BC DE F0 (BIG_ENDIAN=1) -> SRAM[0]=32'h12345678, SRAM[4]=32'h9ABCDEF0, done pulses once, words_written=2, cpu_hold falls with done.
- Same stream with BIG_ENDIAN=0 -> SRAM[0]=32'h78563412. Hold byte_valid low for 5 cycles between bytes -> result unchanged, no extra writes.
- SRAM model corrupts bit 0 on the write to address 4 -> err=1 in the cycle after VERIFY, words_written=1, no done. A later start with num_words=1 clears err and loads normally.
- start with num_words=0 -> done in the next cycle, no mem_cs activity. start with num_words=MAX_WORDS+1 -> err=1, byte_ready stays 0.
- Assert rst_n=0 after 2 bytes of word 1 (num_words=3) -> all outputs 0 immediately. A new load with num_words=1 writes only BASE_ADDR with the fresh 4 bytes.
- Pulse start during COLLECT with num_words=7 -> ignored; the original num_words completes. Assertion across all tests: mem_we&&mem_oe is never 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// State codes, word geometry and SRAM strobe patterns.
package imem_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_VERIFY  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam int          WORD_BYTES  = 4;
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    typedef struct packed {
        logic cs;
        logic oe;
        logic we;
    } strobe_t;

    localparam strobe_t STB_OFF = 3'b000;
    localparam strobe_t STB_RD  = 3'b110;
    localparam strobe_t STB_WR  = 3'b101;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus the SRAM bus shared with fetch.
// master = loader side, slave = stream source / SRAM side.
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        input  byte_valid, byte_data, mem_dout,
        output byte_ready, mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

    modport slave (
        output byte_valid, byte_data, mem_dout,
        input  byte_ready, mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Accepts stream bytes and assembles them into 32-bit words.
// word_ready_o pulses in the cycle the last byte of a word is taken.
module word_packer
    import imem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  lane;
    logic        fire;

    assign byte_ready_o = en_i;
    assign fire         = en_i && byte_valid_i;
    assign word_ready_o = fire && (idx_q == 2'(WORD_BYTES - 1));
    assign word_o       = word_q;
    assign lane         = BIG_ENDIAN ? (2'd3 - idx_q) : idx_q;

    // Place the accepted byte in its lane and advance the slot index.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (fire) begin
            idx_d = idx_q + 2'd1;
            word_d[{lane, 3'b000} +: 8] = byte_data_i;
        end
    end

    // Slot index and partial word; reset drops any half-built word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image into instruction SRAM with write-then-verify.
// Holds the CPU off while loading or after a failed verify.
module imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 1024,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   num_words,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   words_written,
    output logic          cpu_hold
);

    localparam logic [15:0] MAXW = 16'(MAX_WORDS);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [15:0] nwords_q, nwords_d;
    logic [31:0] word;
    logic [31:0] din;
    logic        word_ready;
    logic        collect;
    logic        clr;
    strobe_t     stb;

    assign collect = (state_q == S_COLLECT);

    word_packer #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (collect),
        .clr_i        (clr),
        .byte_valid_i (bus.byte_valid),
        .byte_data_i  (bus.byte_data),
        .byte_ready_o (bus.byte_ready),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // State, address, count and latched length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= BASE_ADDR;
            count_q  <= 16'd0;
            nwords_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            nwords_q <= nwords_d;
        end
    end

    // Next state; a start is only honoured from IDLE or ERROR.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        nwords_d = nwords_q;
        clr      = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    clr      = 1'b1;
                    addr_d   = BASE_ADDR;
                    count_d  = 16'd0;
                    nwords_d = num_words;
                    if (num_words == 16'd0) state_d = S_DONE;
                    else if (num_words > MAXW) state_d = S_ERROR;
                    else state_d = S_COLLECT;
                end
            end
            S_COLLECT: if (word_ready) state_d = S_WRITE;
            S_WRITE:   state_d = S_VERIFY;
            S_VERIFY: begin
                if (bus.mem_dout != word) begin
                    state_d = S_ERROR;
                end else begin
                    count_d = count_q + 16'd1;
                    addr_d  = addr_q + ADDR_STRIDE;
                    state_d = (count_q + 16'd1 == nwords_q) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // SRAM strobes and write data; write and read never overlap.
    always_comb begin
        stb = STB_OFF;
        din = 32'd0;
        unique case (state_q)
            S_WRITE: begin
                stb = STB_WR;
                din = word;
            end
            S_VERIFY: stb = STB_RD;
            default:  stb = STB_OFF;
        endcase
    end

    assign bus.mem_cs    = stb.cs;
    assign bus.mem_oe    = stb.oe;
    assign bus.mem_we    = stb.we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din;
    assign busy          = (state_q == S_COLLECT) || (state_q == S_WRITE) ||
                           (state_q == S_VERIFY);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERROR);
    assign cpu_hold      = busy || err;
    assign words_written = count_q;

endmodule
